// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
//   Reset/lock sequencer for a PLL. Runs on the PLL's free-running reference
//   clock. Each attempt holds the PLL in reset for a fixed time, then waits for
//   LOCKED with a timeout. Lock is qualified as a run of consecutive
//   synchronized-high cycles. Only then is the downstream system reset
//   released. Timeouts retry up to MAX_RETRIES times before the block parks in
//   FAIL. Losing lock while running restarts the sequence.
//
// Ports
//   CLKIN1        in   reference clock (sole clock)
//   RST           in   synchronous active-high reset
//   LOCKED        in   PLL lock indicator, asynchronous to CLKIN1
//   FORCE_RELOCK  in   single-cycle request to restart sequencing
//   PLL_RST       out  PLL reset input
//   PLL_PWRDWN    out  PLL power-down input
//   SYS_RST       out  active-high reset to downstream logic
//   READY         out  lock qualified, system running
//   FAIL          out  retries exhausted
//   RETRY_CNT     out  retries used in the current sequence (saturates at 255)
//
// Build option
//   PLL_LOCK_CTRL_PWRDWN_EN : when defined, PLL_PWRDWN is asserted while in
//   FAIL. When undefined, PLL_PWRDWN is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// HOLD      | PLL_RST asserted, counting the reset-hold time
// WAIT_LOCK | PLL_RST released, waiting for synchronized LOCKED
// STABLE    | LOCKED seen, counting consecutive high cycles
// RUN       | lock qualified, SYS_RST released, READY asserted
// FAIL      | retries exhausted, PLL held in reset
module pll_lock_ctrl #(
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int MAX_RETRIES        = 3,
  parameter int CNT_W              = 17
) (
  input  logic       CLKIN1,
  input  logic       RST,
  input  logic       LOCKED,
  input  logic       FORCE_RELOCK,
  output logic       PLL_RST,
  output logic       PLL_PWRDWN,
  output logic       SYS_RST,
  output logic       READY,
  output logic       FAIL,
  output logic [7:0] RETRY_CNT
);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_DONE = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRIES);
  // The cycle that detects lock already counts as the first stable cycle.
  localparam bit               STAB_ONE  = (LOCK_STABLE_CYCLES <= 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [CNT_W-1:0] stab_inc;
  logic [7:0]       retry_q, retry_d;
  logic             lock_meta_q, lock_meta_d;
  logic             lock_sync_q, lock_sync_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             locked_s;
  logic             timeout;

  assign locked_s = lock_sync_q;
  assign stab_inc = stab_cnt_q + CNT_W'(1);
  assign timeout  = (tmo_cnt_q >= TMO_LAST);

  always_comb begin
    lock_meta_d = LOCKED;
    lock_sync_d = lock_meta_q;
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    stab_cnt_d = stab_cnt_q;
    retry_d    = retry_q;

    case (state_q)
      S_HOLD: begin
        if (FORCE_RELOCK) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q >= HOLD_LAST) begin
          state_d    = S_WAIT_LOCK;
          hold_cnt_d = '0;
          tmo_cnt_d  = '0;
          stab_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_LOCK, S_STABLE: begin
        // The timeout window spans both acquisition states and is only
        // restarted when a new attempt leaves HOLD.
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        if (FORCE_RELOCK) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
          stab_cnt_d = '0;
        end else if (timeout) begin
          hold_cnt_d = '0;
          stab_cnt_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_HOLD;
            retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
          end
        end else if (state_q == S_WAIT_LOCK) begin
          if (locked_s) begin
            stab_cnt_d = CNT_W'(1);
            if (STAB_ONE) begin
              state_d = S_RUN;
              retry_d = '0;
            end else begin
              state_d = S_STABLE;
            end
          end
        end else begin
          if (!locked_s) begin
            state_d    = S_WAIT_LOCK;
            stab_cnt_d = '0;
          end else begin
            stab_cnt_d = stab_inc;
            if (stab_inc >= STAB_DONE) begin
              state_d = S_RUN;
              retry_d = '0;
            end
          end
        end
      end

      S_RUN: begin
        if (!locked_s || FORCE_RELOCK) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
          stab_cnt_d = '0;
        end
      end

      S_FAIL: begin
        if (FORCE_RELOCK) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
          retry_d    = '0;
        end
      end

      default: begin
        state_d    = S_HOLD;
        hold_cnt_d = '0;
        tmo_cnt_d  = '0;
        stab_cnt_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_comb begin
    pll_rst_d = (state_d == S_HOLD) || (state_d == S_FAIL);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge CLKIN1) begin
    if (RST) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      stab_cnt_q  <= '0;
      retry_q     <= '0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      retry_q     <= retry_d;
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

`ifdef PLL_LOCK_CTRL_PWRDWN_EN
  logic pwrdwn_q, pwrdwn_d;

  always_comb begin
    pwrdwn_d = (state_d == S_FAIL);
  end

  always_ff @(posedge CLKIN1) begin
    if (RST) begin
      pwrdwn_q <= 1'b0;
    end else begin
      pwrdwn_q <= pwrdwn_d;
    end
  end

  assign PLL_PWRDWN = pwrdwn_q;
`else
  assign PLL_PWRDWN = 1'b0;
`endif

  assign PLL_RST   = pll_rst_q;
  assign SYS_RST   = sys_rst_q;
  assign READY     = ready_q;
  assign FAIL      = fail_q;
  assign RETRY_CNT = retry_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Testbench for pll_lock_ctrl. Directed scenarios followed by a randomized
// LOCKED / FORCE_RELOCK / RST phase. Every cycle the DUT outputs are compared
// against a behavioural model that tracks the sequence as phases with elapsed
// times and a lock streak.
module tb_pll_lock_ctrl;

  localparam int HOLD_CYC = 4;
  localparam int TMO_CYC  = 40;
  localparam int STAB_CYC = 8;
  localparam int MAX_RTY  = 2;

  localparam int PH_HOLD   = 0;
  localparam int PH_ACQ    = 1;
  localparam int PH_RUN    = 2;
  localparam int PH_FAILED = 3;

`ifdef PLL_LOCK_CTRL_PWRDWN_EN
  localparam bit PWRDWN_ON = 1'b1;
`else
  localparam bit PWRDWN_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       locked;
  logic       force_relock;
  logic       pll_rst;
  logic       pll_pwrdwn;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [7:0] retry_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int m_ph      = PH_HOLD;
  int m_hold    = 0;
  int m_age     = 0;
  int m_streak  = 0;
  int m_retries = 0;
  bit m_meta    = 1'b0;
  bit m_sync    = 1'b0;

  int n;
  int seg_left = 0;
  bit sys_low;

  pll_lock_ctrl #(
    .RST_HOLD_CYCLES   (HOLD_CYC),
    .LOCK_TIMEOUT      (TMO_CYC),
    .LOCK_STABLE_CYCLES(STAB_CYC),
    .MAX_RETRIES       (MAX_RTY),
    .CNT_W             (17)
  ) dut (
    .CLKIN1      (clk),
    .RST         (rst),
    .LOCKED      (locked),
    .FORCE_RELOCK(force_relock),
    .PLL_RST     (pll_rst),
    .PLL_PWRDWN  (pll_pwrdwn),
    .SYS_RST     (sys_rst),
    .READY       (ready),
    .FAIL        (fail),
    .RETRY_CNT   (retry_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit ls;
    if (rst) begin
      m_ph = PH_HOLD; m_hold = 0; m_age = 0; m_streak = 0; m_retries = 0;
      m_meta = 1'b0; m_sync = 1'b0;
      return;
    end
    ls = m_sync;
    m_sync = m_meta;
    m_meta = locked;
    case (m_ph)
      PH_HOLD: begin
        if (force_relock) m_hold = 0;
        else begin
          m_hold++;
          if (m_hold == HOLD_CYC) begin
            m_ph = PH_ACQ; m_age = 0; m_streak = 0;
          end
        end
      end
      PH_ACQ: begin
        m_age++;
        if (force_relock) begin
          m_ph = PH_HOLD; m_hold = 0;
        end else if (m_age == TMO_CYC) begin
          if (m_retries == MAX_RTY) m_ph = PH_FAILED;
          else begin
            m_retries = (m_retries < 255) ? m_retries + 1 : 255;
            m_ph = PH_HOLD; m_hold = 0;
          end
        end else begin
          m_streak = ls ? m_streak + 1 : 0;
          if (m_streak >= STAB_CYC) begin
            m_ph = PH_RUN; m_retries = 0;
          end
        end
      end
      PH_RUN: begin
        if (!ls || force_relock) begin
          m_ph = PH_HOLD; m_hold = 0;
        end
      end
      default: begin
        if (force_relock) begin
          m_ph = PH_HOLD; m_hold = 0; m_retries = 0;
        end
      end
    endcase
  endtask

  function automatic logic [12:0] model_outs();
    logic p_rst, p_dwn, s_rst, rdy, fl;
    p_rst = (m_ph == PH_HOLD) || (m_ph == PH_FAILED);
    p_dwn = PWRDWN_ON && (m_ph == PH_FAILED);
    s_rst = (m_ph != PH_RUN);
    rdy   = (m_ph == PH_RUN);
    fl    = (m_ph == PH_FAILED);
    return {p_rst, p_dwn, s_rst, rdy, fl, 8'(m_retries)};
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_eq("outs", {pll_rst, pll_pwrdwn, sys_rst, ready, fail, retry_cnt}, model_outs());
  endtask

  initial begin
    rst = 1'b1;
    locked = 1'b0;
    force_relock = 1'b0;
    @(negedge clk);
    repeat (3) step();
    check_eq("rst_outs", {pll_rst, pll_pwrdwn, sys_rst, ready, fail, retry_cnt}, 13'b1_0_1_0_0_00000000);

    // 1: basic bring-up
    rst = 1'b0;
    n = 0; while (pll_rst && n < 100) begin n++; step(); end
    check_eq("s1_hold_width", n, HOLD_CYC);
    repeat (10) step();
    locked = 1'b1;
    n = 0; while (!ready && n < 100) begin step(); n++; end
    check_eq("s1_ready_lat", n, 2 + STAB_CYC);
    check_eq("s1_sys_rst", sys_rst, 0);
    check_eq("s1_retry", retry_cnt, 0);

    // 4: lock loss while running
    repeat (5) step();
    locked = 1'b0;
    n = 0; while (ready && n < 100) begin step(); n++; end
    check_eq("s4_drop_lat", n, 3);
    check_eq("s4_sys_rst", sys_rst, 1);
    n = 0; while (pll_rst && n < 100) begin n++; step(); end
    check_eq("s4_hold_width", n, HOLD_CYC);
    locked = 1'b1;
    n = 0; while (!ready && n < 100) begin step(); n++; end
    check_eq("s4_relock_lat", n, 2 + STAB_CYC);

    // 3: one-cycle glitch during qualification
    locked = 1'b0;
    n = 0; while (ready && n < 100) begin step(); n++; end
    n = 0; while (pll_rst && n < 100) begin n++; step(); end
    locked = 1'b1;
    repeat (5) step();
    locked = 1'b0;
    step();
    locked = 1'b1;
    sys_low = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      step(); n++;
      if (!sys_rst && !ready) sys_low = 1'b1;
    end
    check_eq("s3_sys_held", sys_low, 0);
    check_eq("s3_ready_lat", n, 2 + STAB_CYC);

    // 2: no lock at all -> retries then fail
    locked = 1'b0;
    n = 0; while (ready && n < 100) begin step(); n++; end
    for (int p = 0; p <= MAX_RTY; p++) begin
      check_eq("s2_retry", retry_cnt, p);
      n = 0; while (pll_rst && n < 100) begin n++; step(); end
      check_eq("s2_pulse", n, HOLD_CYC);
      n = 0; while (!pll_rst && n < 100) begin n++; step(); end
      check_eq("s2_gap", n, TMO_CYC);
    end
    check_eq("s2_fail_flag", fail, 1);
    check_eq("s2_pll_rst", pll_rst, 1);
    check_eq("s2_sys_rst", sys_rst, 1);
    check_eq("s2_ready", ready, 0);
    check_eq("s2_retry_end", retry_cnt, MAX_RTY);
    check_eq("s2_pwrdwn", pll_pwrdwn, PWRDWN_ON);
    repeat (20) step();
    check_eq("s2_fail_held", fail, 1);

    // 5: forced relock out of fail
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    check_eq("s5_fail_clr", fail, 0);
    check_eq("s5_retry_clr", retry_cnt, 0);
    check_eq("s5_pwrdwn", pll_pwrdwn, 0);
    n = 0; while (pll_rst && n < 100) begin n++; step(); end
    check_eq("s5_hold_width", n, HOLD_CYC);
    locked = 1'b1;
    n = 0; while (!ready && n < 100) begin step(); n++; end
    check_eq("s5_ready_lat", n, 2 + STAB_CYC);

    // 6: reset in the middle of qualification with one retry used
    locked = 1'b0;
    n = 0; while (ready && n < 100) begin step(); n++; end
    n = 0; while (pll_rst && n < 100) begin n++; step(); end
    n = 0; while (!pll_rst && n < 100) begin n++; step(); end
    check_eq("s6_retry_pre", retry_cnt, 1);
    n = 0; while (pll_rst && n < 100) begin n++; step(); end
    locked = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("s6_retry", retry_cnt, 0);
    check_eq("s6_sys_rst", sys_rst, 1);
    check_eq("s6_pll_rst", pll_rst, 1);
    check_eq("s6_ready", ready, 0);
    n = 0; while (pll_rst && n < 100) begin n++; step(); end
    check_eq("s6_hold_width", n, HOLD_CYC);
    n = 0; while (!ready && n < 100) begin step(); n++; end
    check_eq("s6_relock", ready, 1);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      if (seg_left == 0) begin
        seg_left = $urandom_range(1, 40);
        locked = ($urandom_range(0, 3) != 0);
      end
      seg_left--;
      force_relock = ($urandom_range(0, 79) == 0);
      rst = ($urandom_range(0, 599) == 0);
      step();
      if (ready && fail) check_eq("ready_and_fail", {ready, fail}, 2'b00);
    end
    rst = 1'b0;
    force_relock = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
